// File: rtl/washer_plant.sv
// washer_plant: behavioural plant model of a washing-machine drum.
// Tracks water level, water temperature, drum speed and door lock.
// Optional fault detection is built when WASHER_PLANT_FAULT_EN is defined;
// otherwise fault/fault_code are tied low and fault_clr is ignored.
module washer_plant #(
    parameter logic [7:0] LEVEL_MAX    = 8'd200,
    parameter logic [7:0] FULL_LEVEL   = 8'd160,
    parameter logic [7:0] FILL_RATE    = 8'd4,
    parameter logic [7:0] DRAIN_RATE   = 8'd5,
    parameter logic [7:0] WASH_SPEED   = 8'd40,
    parameter logic [7:0] SPIN_SPEED   = 8'd120,
    parameter logic [7:0] RAMP         = 8'd4,
    parameter logic [7:0] UNLOCK_DELAY = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valve_in_cold,
    input  logic       valve_in_hot,
    input  logic       valve_out,
    input  logic [1:0] motor,
    input  logic       fault_clr,
    output logic [7:0] water_level,
    output logic       water_full,
    output logic       water_empty,
    output logic [7:0] water_temp,
    output logic [7:0] drum_speed,
    output logic       door_locked,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam logic [7:0] TEMP_COLD = 8'd20;
    localparam logic [7:0] TEMP_HOT  = 8'd90;
    localparam logic [7:0] TEMP_MIX  = 8'd50;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_COOLDOWN = 2'd2
    } lock_state_e;

    logic [7:0]        level_q, level_d;
    logic [7:0]        temp_q, temp_d;
    logic [7:0]        speed_q, speed_d;
    logic [7:0]        cnt_q, cnt_d;
    lock_state_e       state_q, state_d;
    logic              door_locked_q, door_locked_d;
    logic              fault_q, fault_d;
    logic [1:0]        fault_code_q, fault_code_d;

    logic [9:0]        fill_s;
    logic [9:0]        drain_s;
    logic signed [9:0] level_sum_s;
    logic [7:0]        target_s;
    logic              activity_s;
    logic              quiet_s;
    logic              water_full_s;

    assign water_full_s = (level_q >= FULL_LEVEL);

    // Next water level: signed sum of inflow and outflow, clamped to [0, LEVEL_MAX].
    always_comb begin
        fill_s      = ({2'b00, FILL_RATE} & {10{valve_in_cold}})
                    + ({2'b00, FILL_RATE} & {10{valve_in_hot}});
        drain_s     = {2'b00, DRAIN_RATE} & {10{valve_out}};
        level_sum_s = $signed({2'b00, level_q}) + $signed(fill_s) - $signed(drain_s);
        if (level_sum_s < $signed(10'd0)) begin
            level_d = 8'd0;
        end else if (level_sum_s > $signed({2'b00, LEVEL_MAX})) begin
            level_d = LEVEL_MAX;
        end else begin
            level_d = level_sum_s[7:0];
        end
    end

    // Next temperature: drift by inlet mix, snap to cold once the drum is empty.
    always_comb begin
        temp_d = temp_q;
        if (level_q == 8'd0) begin
            temp_d = TEMP_COLD;
        end else begin
            case ({valve_in_hot, valve_in_cold})
                2'b10: begin
                    if (temp_q < TEMP_HOT) temp_d = temp_q + 8'd1;
                    else                   temp_d = temp_q;
                end
                2'b01: begin
                    if (temp_q > TEMP_COLD) temp_d = temp_q - 8'd1;
                    else                    temp_d = temp_q;
                end
                2'b11: begin
                    if (temp_q < TEMP_MIX)      temp_d = temp_q + 8'd1;
                    else if (temp_q > TEMP_MIX) temp_d = temp_q - 8'd1;
                    else                        temp_d = temp_q;
                end
                default: temp_d = temp_q;
            endcase
        end
    end

    // Next drum speed: ramp toward the motor target without overshoot.
    always_comb begin
        case (motor)
            2'd1:    target_s = WASH_SPEED;
            2'd2:    target_s = SPIN_SPEED;
            default: target_s = 8'd0;  // off and the illegal code both stop the drum
        endcase
        speed_d = speed_q;
        if (speed_q < target_s) begin
            if ((target_s - speed_q) > RAMP) speed_d = speed_q + RAMP;
            else                             speed_d = target_s;
        end else if (speed_q > target_s) begin
            if ((speed_q - target_s) > RAMP) speed_d = speed_q - RAMP;
            else                             speed_d = target_s;
        end else begin
            speed_d = speed_q;
        end
    end

    // Door lock next state: lock on any activity, unlock after a quiet cooldown.
    always_comb begin
        activity_s = valve_in_cold | valve_in_hot | valve_out
                   | (motor != 2'd0) | (level_q != 8'd0);
        quiet_s    = !activity_s && (speed_q == 8'd0);
        state_d    = state_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_UNLOCKED: begin
                cnt_d = 8'd0;
                if (activity_s) state_d = ST_LOCKED;
                else            state_d = ST_UNLOCKED;
            end
            ST_LOCKED: begin
                cnt_d = 8'd0;
                if (quiet_s) state_d = ST_COOLDOWN;
                else         state_d = ST_LOCKED;
            end
            ST_COOLDOWN: begin
                if (activity_s) begin
                    state_d = ST_LOCKED;
                    cnt_d   = 8'd0;
                end else if (({1'b0, cnt_q} + 9'd1) >= {1'b0, UNLOCK_DELAY}) begin
                    state_d = ST_UNLOCKED;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                cnt_d   = 8'd0;
            end
        endcase
        door_locked_d = (state_d != ST_UNLOCKED);
    end

`ifdef WASHER_PLANT_FAULT_EN
    logic [1:0] det_code_s;

    // Fault latch: first detected fault wins; clear only when conditions are gone.
    always_comb begin
        if ((valve_in_cold | valve_in_hot) && (level_q == LEVEL_MAX)) begin
            det_code_s = 2'd1;
        end else if (motor == 2'd3) begin
            det_code_s = 2'd2;
        end else if ((motor == 2'd2) && water_full_s) begin
            det_code_s = 2'd3;
        end else begin
            det_code_s = 2'd0;
        end
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        if (!fault_q) begin
            if (det_code_s != 2'd0) begin
                fault_d      = 1'b1;
                fault_code_d = det_code_s;
            end else begin
                fault_d      = 1'b0;
                fault_code_d = 2'd0;
            end
        end else if (fault_clr && (det_code_s == 2'd0)) begin
            fault_d      = 1'b0;
            fault_code_d = 2'd0;
        end else begin
            fault_d      = fault_q;
            fault_code_d = fault_code_q;
        end
    end
`else
    logic unused_fault_clr_s;
    assign unused_fault_clr_s = fault_clr;

    // Fault logic absent: keep the fault outputs permanently clear.
    always_comb begin
        fault_d      = 1'b0;
        fault_code_d = 2'd0;
    end
`endif

    // State registers for plant dynamics, door lock and fault latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q       <= 8'd0;
            temp_q        <= TEMP_COLD;
            speed_q       <= 8'd0;
            state_q       <= ST_UNLOCKED;
            cnt_q         <= 8'd0;
            door_locked_q <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= 2'd0;
        end else begin
            level_q       <= level_d;
            temp_q        <= temp_d;
            speed_q       <= speed_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            door_locked_q <= door_locked_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
        end
    end

    assign water_level = level_q;
    assign water_full  = water_full_s;
    assign water_empty = (level_q == 8'd0);
    assign water_temp  = temp_q;
    assign drum_speed  = speed_q;
    assign door_locked = door_locked_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_washer_plant.sv
// Self-checking bench for washer_plant: a vector table plus hand sequences,
// expected records queued at drive time and compared after the clock edge.
module tb_washer_plant;

`ifdef WASHER_PLANT_FAULT_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    localparam logic [7:0] M_ALL = 8'hFF;

    typedef struct {
        logic       cold, hot, vout;
        logic [1:0] motor;
        logic       clr;
        logic [7:0] level;
        logic       full, empty;
        logic [7:0] temp, speed;
        logic       locked, flt;
        logic [1:0] code;
        logic [7:0] mask;
    } vec_t;

    logic       clk, rst;
    logic       valve_in_cold, valve_in_hot, valve_out, fault_clr;
    logic [1:0] motor;
    logic [7:0] water_level, water_temp, drum_speed;
    logic       water_full, water_empty, door_locked, fault;
    logic [1:0] fault_code;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    vec_t exp_q[$];
    vec_t tbl[22];

    washer_plant dut (
        .clk(clk), .rst(rst),
        .valve_in_cold(valve_in_cold), .valve_in_hot(valve_in_hot),
        .valve_out(valve_out), .motor(motor), .fault_clr(fault_clr),
        .water_level(water_level), .water_full(water_full), .water_empty(water_empty),
        .water_temp(water_temp), .drum_speed(drum_speed), .door_locked(door_locked),
        .fault(fault), .fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic c, input logic h, input logic o,
                                input logic [1:0] m, input logic cl,
                                input int lvl, input int tmp, input int spd,
                                input logic lk, input logic f, input int cd);
        vec_t v;
        v.cold = c; v.hot = h; v.vout = o; v.motor = m; v.clr = cl;
        v.level = lvl[7:0]; v.full = (lvl >= 160); v.empty = (lvl == 0);
        v.temp = tmp[7:0]; v.speed = spd[7:0];
        v.locked = lk; v.flt = f; v.code = cd[1:0];
        v.mask = M_ALL;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else            pass_cnt++;
    endtask

    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL scoreboard: got empty queue expected a record");
        end else begin
            e = exp_q.pop_front();
            if (e.mask[0]) chk("water_level", int'(water_level), int'(e.level));
            if (e.mask[1]) chk("water_full",  int'(water_full),  int'(e.full));
            if (e.mask[2]) chk("water_empty", int'(water_empty), int'(e.empty));
            if (e.mask[3]) chk("water_temp",  int'(water_temp),  int'(e.temp));
            if (e.mask[4]) chk("drum_speed",  int'(drum_speed),  int'(e.speed));
            if (e.mask[5]) chk("door_locked", int'(door_locked), int'(e.locked));
            if (e.mask[6]) chk("fault",       int'(fault),       int'(e.flt));
            if (e.mask[7]) chk("fault_code",  int'(fault_code),  int'(e.code));
        end
    endtask

    task automatic apply(input vec_t v);
        valve_in_cold = v.cold; valve_in_hot = v.hot; valve_out = v.vout;
        motor = v.motor; fault_clr = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_level"},  int'(water_level), 0);
        chk({tag, "_empty"},  int'(water_empty), 1);
        chk({tag, "_full"},   int'(water_full),  0);
        chk({tag, "_temp"},   int'(water_temp),  20);
        chk({tag, "_speed"},  int'(drum_speed),  0);
        chk({tag, "_locked"}, int'(door_locked), 0);
        chk({tag, "_fault"},  int'(fault),       0);
        chk({tag, "_code"},   int'(fault_code),  0);
    endtask

    task automatic do_reset();
        valve_in_cold = 1'b0; valve_in_hot = 1'b0; valve_out = 1'b0;
        motor = 2'd0; fault_clr = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        valve_in_cold = 1'b0; valve_in_hot = 1'b0; valve_out = 1'b0;
        motor = 2'd0; fault_clr = 1'b0;

        //           c  h  o  m    clr lvl tmp spd lk f cd
        tbl[0]  = mk(1, 0, 0, 2'd0, 0,  4, 20, 0, 1, 0, 0);
        tbl[1]  = mk(1, 0, 0, 2'd0, 0,  8, 20, 0, 1, 0, 0);
        tbl[2]  = mk(0, 1, 0, 2'd0, 0, 12, 21, 0, 1, 0, 0);
        tbl[3]  = mk(0, 1, 0, 2'd0, 0, 16, 22, 0, 1, 0, 0);
        tbl[4]  = mk(1, 1, 0, 2'd0, 0, 24, 23, 0, 1, 0, 0);
        tbl[5]  = mk(1, 1, 1, 2'd0, 0, 27, 24, 0, 1, 0, 0);
        tbl[6]  = mk(0, 0, 1, 2'd0, 0, 22, 24, 0, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 2'd1, 0, 22, 24, 4, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 2'd1, 0, 22, 24, 8, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 2'd0, 0, 22, 24, 4, 1, 0, 0);
        tbl[10] = mk(1, 0, 0, 2'd0, 0, 26, 23, 0, 1, 0, 0);
        tbl[11] = mk(0, 0, 1, 2'd0, 0, 21, 23, 0, 1, 0, 0);
        tbl[12] = mk(0, 0, 1, 2'd0, 0, 16, 23, 0, 1, 0, 0);
        tbl[13] = mk(0, 0, 1, 2'd0, 0, 11, 23, 0, 1, 0, 0);
        tbl[14] = mk(0, 0, 1, 2'd0, 0,  6, 23, 0, 1, 0, 0);
        tbl[15] = mk(0, 0, 1, 2'd0, 0,  1, 23, 0, 1, 0, 0);
        tbl[16] = mk(0, 0, 1, 2'd0, 0,  0, 23, 0, 1, 0, 0);
        tbl[17] = mk(0, 0, 0, 2'd0, 0,  0, 20, 0, 1, 0, 0);
        tbl[18] = mk(0, 0, 0, 2'd0, 0,  0, 20, 0, 1, 0, 0);
        tbl[19] = mk(0, 0, 0, 2'd0, 0,  0, 20, 0, 1, 0, 0);
        tbl[20] = mk(0, 0, 0, 2'd0, 0,  0, 20, 0, 1, 0, 0);
        tbl[21] = mk(0, 0, 0, 2'd0, 0,  0, 20, 0, 0, 0, 0);

        // Reset values while reset is held.
        #1 rst = 1'b1;
        #2 check_reset_values("rst");
        @(negedge clk);
        rst = 1'b0;

        // Vector table: fill, temperature drift, wash ramp, drain, cooldown unlock.
        for (int i = 0; i < 22; i++) apply(tbl[i]);

        // Cooldown interrupted by a cold pulse, then a clean cooldown.
        apply(mk(0, 0, 0, 2'd1, 0, 0, 20, 4, 1, 0, 0));
        apply(mk(0, 0, 0, 2'd0, 0, 0, 20, 0, 1, 0, 0));
        apply(mk(0, 0, 0, 2'd0, 0, 0, 20, 0, 1, 0, 0));
        apply(mk(0, 0, 0, 2'd0, 0, 0, 20, 0, 1, 0, 0));
        apply(mk(1, 0, 0, 2'd0, 0, 4, 20, 0, 1, 0, 0));
        apply(mk(0, 0, 1, 2'd0, 0, 0, 20, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++) apply(mk(0, 0, 0, 2'd0, 0, 0, 20, 0, 1, 0, 0));
        apply(mk(0, 0, 0, 2'd0, 0, 0, 20, 0, 0, 0, 0));

        // Spin ramp up to 120 and hold, then ramp down and unlock.
        for (int i = 1; i <= 35; i++)
            apply(mk(0, 0, 0, 2'd2, 0, 0, 20, (4 * i > 120) ? 120 : 4 * i, 1, 0, 0));
        for (int i = 1; i <= 35; i++)
            apply(mk(0, 0, 0, 2'd0, 0, 0, 20, (120 - 4 * i < 0) ? 0 : 120 - 4 * i,
                     (i < 35), 0, 0));

        // Both inlets: saturate at 200, overflow fault one cycle later.
        for (int i = 1; i <= 50; i++)
            apply(mk(1, 1, 0, 2'd0, 0, (8 * i > 200) ? 200 : 8 * i,
                     (19 + i > 50) ? 50 : 19 + i, 0, 1,
                     FE && (i >= 26), (FE && (i >= 26)) ? 1 : 0));
        for (int i = 1; i <= 40; i++)
            apply(mk(0, 0, 1, 2'd0, 0, 200 - 5 * i, 50, 0, 1, FE, FE ? 1 : 0));
        apply(mk(0, 0, 0, 2'd0, 1, 0, 20, 0, 1, 0, 0));

        // Illegal motor at level 160, clear refused while motor=3, accepted later.
        for (int i = 1; i <= 20; i++)
            apply(mk(1, 1, 0, 2'd0, 0, 8 * i, 19 + i, 0, 1, 0, 0));
        apply(mk(0, 0, 0, 2'd3, 0, 160, 39, 0, 1, FE, FE ? 2 : 0));
        apply(mk(0, 0, 0, 2'd3, 1, 160, 39, 0, 1, FE, FE ? 2 : 0));
        for (int i = 1; i <= 32; i++)
            apply(mk(0, 0, 1, 2'd0, 0, 160 - 5 * i, 39, 0, 1, FE, FE ? 2 : 0));
        apply(mk(0, 0, 0, 2'd0, 1, 0, 20, 0, 1, 0, 0));

        // Spin while full, then clear, then simultaneous overflow + illegal motor.
        for (int i = 1; i <= 20; i++)
            apply(mk(1, 1, 0, 2'd0, 0, 8 * i, 19 + i, 0, 1, 0, 0));
        apply(mk(0, 0, 0, 2'd2, 0, 160, 39, 4, 1, FE, FE ? 3 : 0));
        apply(mk(0, 0, 0, 2'd0, 1, 160, 39, 0, 1, 0, 0));
        for (int i = 1; i <= 5; i++)
            apply(mk(1, 1, 0, 2'd0, 0, 160 + 8 * i, 39 + i, 0, 1, 0, 0));
        apply(mk(1, 1, 0, 2'd3, 0, 200, 45, 0, 1, FE, FE ? 1 : 0));

        // Asynchronous reset in the middle of a fill-and-spin.
        do_reset();
        for (int i = 1; i <= 20; i++)
            apply(mk(1, 0, 0, 2'd2, 0, 4 * i, 20, 4 * i, 1, 0, 0));
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;
        valve_in_cold = 1'b0; motor = 2'd0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/washer_plant.md
WASHER_PLANT -- requirements
Module: washer_plant

Interface
REQ-001 SHALL have parameter LEVEL_MAX, default 8'd200, meaning drum water-level saturation value.
REQ-002 SHALL have parameter FULL_LEVEL, default 8'd160, meaning threshold for water_full.
REQ-003 SHALL have parameter FILL_RATE, default 8'd4, meaning level increment per open inlet valve per cycle.
REQ-004 SHALL have parameter DRAIN_RATE, default 8'd5, meaning level decrement per cycle while draining.
REQ-005 SHALL have parameter WASH_SPEED, default 8'd40, SPIN_SPEED default 8'd120, RAMP default 8'd4, UNLOCK_DELAY default 8'd4.
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports: valve_in_cold  in  1; valve_in_hot  in  1; valve_out  in  1; motor  in  2  (0 off, 1 wash, 2 spin, 3 illegal); fault_clr  in  1  clear latched fault.
REQ-008 SHALL have ports: water_level  out  8; water_full  out  1; water_empty  out  1; water_temp  out  8; drum_speed  out  8; door_locked  out  1; fault  out  1; fault_code  out  2.

Function
REQ-009 Level SHALL update every cycle: level + FILL_RATE*(cold+hot) - DRAIN_RATE*valve_out, computed in 10-bit signed, clamped to [0, LEVEL_MAX].
REQ-010 water_full SHALL be combinational (water_level >= FULL_LEVEL); water_empty SHALL be (water_level == 0).
REQ-011 Temperature SHALL be a register: hot only -> +1/cycle up to 90; cold only -> -1/cycle down to 20; both -> step 1 toward 50; neither -> hold; forced to 20 in the cycle after water_level reaches 0.
REQ-012 Motor target SHALL be 0/WASH_SPEED/SPIN_SPEED for motor 0/1/2; motor 3 SHALL be treated as target 0.
REQ-013 drum_speed SHALL move toward target by RAMP per cycle, never overshooting (lands exactly on target).
REQ-014 Door lock FSM states: UNLOCKED, LOCKED, COOLDOWN.
REQ-015 UNLOCKED -> LOCKED next cycle when any valve open, motor != 0, or water_level != 0.
REQ-016 LOCKED -> COOLDOWN when all valves closed, motor == 0, drum_speed == 0, water_level == 0.
REQ-017 COOLDOWN SHALL count UNLOCK_DELAY cycles then go UNLOCKED; any activity per REQ-015 during count SHALL return to LOCKED and reset count.
REQ-018 door_locked SHALL be 1 in LOCKED and COOLDOWN.
REQ-019 Fault codes: 1 overflow (inlet open while level == LEVEL_MAX), 2 illegal motor (motor == 3), 3 spin while water_full (motor == 2 and water_full).
REQ-020 fault SHALL latch on the cycle after detection; first fault wins, fault_code held until cleared.
REQ-021 Simultaneous faults SHALL record lowest code number.
REQ-022 fault_clr SHALL clear fault/fault_code next cycle only if no fault condition is present that cycle; else ignored.
REQ-023 Plant dynamics (level, temp, speed) SHALL continue regardless of fault.

Reset
REQ-024 On rst: water_level 0, water_temp 20, drum_speed 0, lock FSM UNLOCKED, counter 0, fault 0, fault_code 0.
REQ-025 Reset mid-fill or mid-spin SHALL take effect immediately, outputs at reset values asynchronously.
REQ-026 First update after rst deassertion SHALL occur on the next rising clk edge.

Configuration
REQ-027 Macro WASHER_PLANT_FAULT_EN: defined -> REQ-019..REQ-022 active.
REQ-028 Macro undefined -> fault and fault_code tied to 0, fault_clr ignored; level clamping and motor-3 handling unchanged.

Verification
REQ-029 Reset, cold only 10 cycles -> water_level 40, water_temp 20, door_locked 1 from cycle 2.
REQ-030 Both inlets from level 0 for 50 cycles -> level saturates 200; with FAULT_EN fault=1, code=1 one cycle after reaching 200 with inlets still open.
REQ-031 motor=2 from rest, level 0 -> drum_speed 4,8,...,120 after 30 cycles, then holds 120; motor=0 -> back to 0 in 30 cycles.
REQ-032 Level 0, speed 0, all inputs idle -> door_locked stays 1 for 4 cycles in COOLDOWN then 0; valve_in_cold pulse at cycle 2 of COOLDOWN -> remains locked.
REQ-033 motor=3 and motor=2 with level 160 same cycle -> fault_code 2; fault_clr while motor=3 -> no clear; clr after motor=0 and drained -> fault 0 next cycle.
REQ-034 rst asserted mid-spin (speed 80, level 100) -> all outputs at REQ-024 values without clock edge.
